// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA raster timing block: 640x480@60 defaults and counter width.
package vga_timing_pkg;
  localparam int POS_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam bit DEF_SYNC_NEG = 1'b1;

  // Half-open window test [lo, hi) on unsigned position values.
  function automatic logic in_window(logic [POS_W-1:0] pos, logic [POS_W-1:0] lo,
                                     logic [POS_W-1:0] hi);
    return (pos >= lo) && (pos < hi);
  endfunction
endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the timing generator (master) and the pixel generator (slave).
interface vga_timing_gen_if #(parameter int FRAME_W = 8);
  import vga_timing_pkg::*;

  logic               en;
  logic               pix_ce;
  logic [POS_W-1:0]   hpos;
  logic [POS_W-1:0]   vpos;
  logic               hsync;
  logic               vsync;
  logic               display_on;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_cnt;

  modport master (
    input  en,
    output pix_ce, hpos, vpos, hsync, vsync, display_on, line_start, frame_start, frame_cnt
  );

  modport slave (
    output en,
    input  pix_ce, hpos, vpos, hsync, vsync, display_on, line_start, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with sync/active flags registered from the next position,
// so they always line up with pos.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  output logic [POS_W-1:0] pos,
  output logic             wrap,
  output logic             sync_act,
  output logic             active
);
  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [POS_W-1:0] LAST    = POS_W'(TOTAL - 1);
  localparam logic [POS_W-1:0] ACT_END = POS_W'(ACTIVE);
  localparam logic [POS_W-1:0] SYNC_LO = POS_W'(ACTIVE + FP);
  localparam logic [POS_W-1:0] SYNC_HI = POS_W'(ACTIVE + FP + SYNC);

  if (TOTAL > (1 << POS_W)) begin : g_bad_total
    $error("vga_axis_counter: TOTAL %0d exceeds %0d-bit position range", TOTAL, POS_W);
  end

  logic [POS_W-1:0] pos_nxt;

  assign wrap    = (pos == LAST);
  assign pos_nxt = wrap ? '0 : pos + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos      <= LAST;
      sync_act <= 1'b0;
      active   <= 1'b0;
    end else if (step) begin
      pos      <= pos_nxt;
      sync_act <= in_window(pos_nxt, SYNC_LO, SYNC_HI);
      active   <= (pos_nxt < ACT_END);
    end
  end
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: positions, syncs, display window and line/frame strobes.
// Optional frame counter enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_NEG = DEF_SYNC_NEG,
  parameter int CLK_DIV  = 1,
  parameter int FRAME_W  = 8
) (
  input logic              clk,
  input logic              rst_n,
  vga_timing_gen_if.master vga
);
  if (CLK_DIV != 1 && CLK_DIV != 2) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be 1 or 2, got %0d", CLK_DIV);
  end

  logic             div_cnt;
  logic             pix_ce;
  logic [POS_W-1:0] h_pos, v_pos;
  logic             h_wrap, v_wrap, h_sync, v_sync, h_act, v_act;
  logic             line_start, frame_start;

  always_ff @(posedge clk) begin
    if (!rst_n)                 div_cnt <= 1'b0;
    else if (vga.en && CLK_DIV == 2) div_cnt <= ~div_cnt;
  end

  assign pix_ce = vga.en && (div_cnt == 1'(CLK_DIV - 1));

  vga_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h (
    .clk(clk), .rst_n(rst_n), .step(pix_ce),
    .pos(h_pos), .wrap(h_wrap), .sync_act(h_sync), .active(h_act)
  );

  vga_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v (
    .clk(clk), .rst_n(rst_n), .step(pix_ce && h_wrap),
    .pos(v_pos), .wrap(v_wrap), .sync_act(v_sync), .active(v_act)
  );

  // Strobes mark only the edge that lands on 0; held or divider-idle cycles read 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= pix_ce && h_wrap;
      frame_start <= pix_ce && h_wrap && v_wrap;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [FRAME_W-1:0] frame_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n)                        frame_cnt <= '0;
    else if (pix_ce && h_wrap && v_wrap) frame_cnt <= frame_cnt + 1'b1;
  end
  assign vga.frame_cnt = frame_cnt;
`else
  assign vga.frame_cnt = '0;
`endif

  assign vga.pix_ce      = pix_ce;
  assign vga.hpos        = h_pos;
  assign vga.vpos        = v_pos;
  assign vga.hsync       = h_sync ^ SYNC_NEG;
  assign vga.vsync       = v_sync ^ SYNC_NEG;
  assign vga.display_on  = h_act && v_act;
  assign vga.line_start  = line_start;
  assign vga.frame_start = frame_start;
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing source for the VGA demo designs. Sits directly upstream of the pixel/colour generator.
- Produces hpos/vpos, hsync/vsync, display_on, and single-cycle line/frame strobes, all from registered state.
- The pixel generator samples these outputs on the same clk edge and uses them to compute RGB.
- Supports a system clock at 1x or 2x the pixel rate through an internal pixel clock-enable.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_NEG, 1, 1 = sync pulses active-low, 0 = active-high
- CLK_DIV, 1, clk cycles per pixel; legal values 1 or 2
- FRAME_W, 8, frame counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  count enable; low freezes all timing state
- pix_ce  out  1  pixel clock-enable; counters advance only on cycles where it is high
- hpos  out  10  current column, 0..H_TOTAL-1
- vpos  out  10  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, polarity per SYNC_NEG
- vsync  out  1  vertical sync, polarity per SYNC_NEG
- display_on  out  1  high iff hpos<H_ACTIVE and vpos<V_ACTIVE
- line_start  out  1  one-clk pulse when hpos becomes 0
- frame_start  out  1  one-clk pulse when (hpos,vpos) becomes (0,0)
- frame_cnt  out  FRAME_W  frames started since reset (see Optional Feature)

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Divider counter div_cnt:
  - Resets to 0.
  - Increments modulo CLK_DIV on every clk while en=1; holds while en=0.
  - pix_ce = en && (div_cnt == CLK_DIV-1), combinational. With CLK_DIV=1, pix_ce = en.
- Reset state:
  - hpos = H_TOTAL-1, vpos = V_TOTAL-1, i.e. the last back-porch pixel.
  - hsync and vsync inactive (1 if SYNC_NEG=1), display_on=0, line_start=0, frame_start=0, frame_cnt=0.
- Advance, on a clk edge with pix_ce=1:
  - If hpos == H_TOTAL-1: hpos <= 0. In the same edge, vpos <= (vpos == V_TOTAL-1) ? 0 : vpos+1.
  - Otherwise: hpos <= hpos+1, vpos unchanged.
- hsync, vsync and display_on are flops computed from the next hpos/vpos. They always describe the current hpos/vpos with zero skew; latency from counter to sync is 0 cycles.
  - hsync active iff H_ACTIVE+H_FP <= hpos < H_ACTIVE+H_FP+H_SYNC (default 656..751).
  - vsync active iff V_ACTIVE+V_FP <= vpos < V_ACTIVE+V_FP+V_SYNC (default 490..491).
- Strobes:
  - line_start = 1 for exactly the clk cycle in which hpos first holds 0.
  - frame_start = 1 for exactly the cycle in which (0,0) is first held.
  - Both are registered and are 0 on all other cycles, including the extra CLK_DIV-1 cycles while hpos remains 0.
- First pix_ce after reset moves to (0,0): frame_start=1, line_start=1, display_on=1.
- en=0: all flops hold; strobes are forced 0 on held cycles.
- rst_n low at any time, mid-line or mid-sync: next edge restores the reset state. There are no partial sync pulses beyond the current cycle.
- All counter compares are unsigned 10-bit. Parameter sets with H_TOTAL or V_TOTAL > 1024 are illegal; the block asserts in simulation.

Optional Feature:
- Macro VGA_FRAME_CNT_EN.
- Defined: frame_cnt increments (wrapping modulo 2^FRAME_W) on the same edge that raises frame_start, so the first frame reads 1. Consumers use it for animation timing.
- Undefined: frame_cnt is tied to 0 and no counter flops are synthesised. The port is present in both builds.

Decomposition:
- Package vga_timing_pkg holds:
  - default 640x480@60 constants: H_ACTIVE..V_BP, H_TOTAL, V_TOTAL;
  - SYNC_NEG default;
  - localparam POS_W=10.
- One sub-module, vga_axis_counter, instantiated twice (horizontal, vertical):
  - parameters ACTIVE/FP/SYNC/BP;
  - inputs step, rst_n;
  - outputs pos, wrap, sync_act, active.
  - The vertical instance's step = horizontal wrap && pix_ce.

Test Plan:
- Reset release, CLK_DIV=1, en=1 -> cycle 1: hpos=0, vpos=0, frame_start=1, line_start=1, display_on=1. Cycle 2: hpos=1, both strobes 0.
- Run one full line -> hsync low exactly for hpos 656..751 (96 cycles). display_on falls at hpos=640. line_start period is 800 clk.
- Run one full frame -> vsync low exactly for vpos 490..491 (1600 clk). frame_start period is 420000 clk. vpos wraps 524->0 at the same edge as hpos 799->0.
- CLK_DIV=2 -> pix_ce alternates 0/1. hpos holds each value for 2 clk. line_start stays 1 clk wide. Line period is 1600 clk.
- en low for 37 cycles at hpos=700 mid-hsync -> hpos, hsync and div_cnt frozen; no strobes. Resume continues at 701 with hsync still active.
- With VGA_FRAME_CNT_EN, FRAME_W=2 -> frame_cnt reads 1,2,3,0 across four frames. Assert rst_n low mid-frame -> next edge gives hpos=799, vpos=524, frame_cnt=0, hsync=vsync=1.
